// File: rtl/icache_ctrl_if.sv
// ============================================================================
//  Module      : icache_ctrl_if
//  Description : CPU fetch handshake and memory line-refill bus bundled for
//                the instruction-cache controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface icache_ctrl_if;
    // CPU fetch side
    logic        cpu_req_valid;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_data;
    // Memory refill side
    logic        mem_rreq;
    logic [31:0] mem_raddr;
    logic        mem_rready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // Controller view
    modport slave (
        input  cpu_req_valid, cpu_req_addr,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        output mem_rreq, mem_raddr,
        input  mem_rready, mem_rvalid, mem_rdata
    );

    // CPU / memory environment view
    modport master (
        output cpu_req_valid, cpu_req_addr,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        input  mem_rreq, mem_raddr,
        output mem_rready, mem_rvalid, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/icache_ctrl.sv
// ============================================================================
//  Module      : icache_ctrl
//  Description : 2-way, 256-set, 16-byte-line instruction cache controller.
//                Looks up external tag/data ways, refills a victim line on a
//                miss (critical word captured in flight) and keeps one LRU
//                bit per set.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_ctrl (
    input  wire logic        clk,
    input  wire logic        rstn,
    icache_ctrl_if.slave     bus,
    // tag / valid ways
    output logic [7:0]       tag_index,
    input  wire logic [19:0] tag_rtag0,
    input  wire logic [19:0] tag_rtag1,
    input  wire logic        tag_rvalid0,
    input  wire logic        tag_rvalid1,
    output logic             tag_we0,
    output logic             tag_we1,
    output logic [19:0]      tag_wtag,
    // data ways
    output logic [9:0]       data_index,
    input  wire logic [31:0] data_rdata0,
    input  wire logic [31:0] data_rdata1,
    output logic             data_we0,
    output logic             data_we1,
    output logic [31:0]      data_wdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MISS   = 3'd2,
        REFILL = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [31:2]   addr_q, addr_d;
    logic          victim_q, victim_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   word_q, word_d;
    logic [255:0]  lru_q, lru_d;

    // Request fields taken from the latched address
    logic [19:0]   req_tag;
    logic [7:0]    req_set;
    logic [1:0]    req_off;
    logic          hit0;
    logic          hit1;

    // Local copies of the bus outputs, driven from the FSM block
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_data;
    logic          rreq;

    // Byte-lane bits of the fetch address carry no information
    logic          unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.cpu_req_addr[1:0]};

    assign req_tag = addr_q[31:12];
    assign req_set = addr_q[11:4];
    assign req_off = addr_q[3:2];

    assign hit0 = tag_rvalid0 && (tag_rtag0 == req_tag);
    assign hit1 = tag_rvalid1 && (tag_rtag1 == req_tag);

    assign tag_index  = req_set;
    assign tag_wtag   = req_tag;
    assign data_wdata = bus.mem_rdata;
    // Refill writes walk the line with the beat counter; lookups read the
    // requested word directly.
    assign data_index = (state_q == REFILL) ? {req_set, cnt_q} : {req_set, req_off};

    assign bus.cpu_req_ready  = req_ready;
    assign bus.cpu_resp_valid = resp_valid;
    assign bus.cpu_resp_data  = resp_data;
    assign bus.mem_rreq       = rreq;
    assign bus.mem_raddr      = {addr_q[31:4], 4'b0000};

    // Next-state, datapath updates and per-state outputs
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        victim_d   = victim_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        lru_d      = lru_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 32'h0;
        rreq       = 1'b0;
        tag_we0    = 1'b0;
        tag_we1    = 1'b0;
        data_we0   = 1'b0;
        data_we1   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.cpu_req_valid) begin
                    addr_d  = bus.cpu_req_addr[31:2];
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                if (hit0 || hit1) begin
                    resp_valid     = 1'b1;
                    resp_data      = hit0 ? data_rdata0 : data_rdata1;
                    // The way just used becomes most recent; replace the other
                    lru_d[req_set] = hit0 ? 1'b1 : 1'b0;
                    state_d        = IDLE;
                end else begin
                    if (!tag_rvalid0) begin
                        victim_d = 1'b0;
                    end else if (!tag_rvalid1) begin
                        victim_d = 1'b1;
                    end else begin
                        victim_d = lru_q[req_set];
                    end
                    state_d = MISS;
                end
            end

            MISS: begin
                rreq = 1'b1;
                if (bus.mem_rready) begin
                    cnt_d   = 2'd0;
                    state_d = REFILL;
                end
            end

            REFILL: begin
                // Writes are suppressed while rstn is low so an aborted
                // refill cannot leave a partially-valid line behind.
                if (bus.mem_rvalid && rstn) begin
                    data_we0 = ~victim_q;
                    data_we1 = victim_q;
                    if (cnt_q == req_off) begin
                        word_d = bus.mem_rdata;
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        tag_we0 = ~victim_q;
                        tag_we1 = victim_q;
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                resp_valid     = 1'b1;
                resp_data      = word_q;
                lru_d[req_set] = ~victim_q;
                state_d        = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            victim_q <= 1'b0;
            cnt_q    <= 2'd0;
            word_q   <= 32'h0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            lru_q    <= lru_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
// ============================================================================
//  Module      : tb_icache_ctrl
//  Description : Scoreboard bench for icache_ctrl with behavioural tag/data
//                ways and a directed CPU/memory driver.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache_ctrl;

    logic        clk;
    logic        rstn;
    icache_ctrl_if bus();

    logic [7:0]  tag_index;
    logic [19:0] tag_rtag0, tag_rtag1;
    logic        tag_rvalid0, tag_rvalid1;
    logic        tag_we0, tag_we1;
    logic [19:0] tag_wtag;
    logic [9:0]  data_index;
    logic [31:0] data_rdata0, data_rdata1;
    logic        data_we0, data_we1;
    logic [31:0] data_wdata;

    icache_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .tag_index   (tag_index),
        .tag_rtag0   (tag_rtag0),
        .tag_rtag1   (tag_rtag1),
        .tag_rvalid0 (tag_rvalid0),
        .tag_rvalid1 (tag_rvalid1),
        .tag_we0     (tag_we0),
        .tag_we1     (tag_we1),
        .tag_wtag    (tag_wtag),
        .data_index  (data_index),
        .data_rdata0 (data_rdata0),
        .data_rdata1 (data_rdata1),
        .data_we0    (data_we0),
        .data_we1    (data_we1),
        .data_wdata  (data_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tag/valid and data ways, valid bits cleared by rstn
    logic [19:0] tagm0 [256];
    logic [19:0] tagm1 [256];
    logic        vm0   [256];
    logic        vm1   [256];
    logic [31:0] dm0   [1024];
    logic [31:0] dm1   [1024];

    assign tag_rtag0   = tagm0[tag_index];
    assign tag_rtag1   = tagm1[tag_index];
    assign tag_rvalid0 = vm0[tag_index];
    assign tag_rvalid1 = vm1[tag_index];
    assign data_rdata0 = dm0[data_index];
    assign data_rdata1 = dm1[data_index];

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 256; i++) begin
                vm0[i] <= 1'b0;
                vm1[i] <= 1'b0;
            end
        end else begin
            if (tag_we0) begin tagm0[tag_index] <= tag_wtag; vm0[tag_index] <= 1'b1; end
            if (tag_we1) begin tagm1[tag_index] <= tag_wtag; vm1[tag_index] <= 1'b1; end
            if (data_we0) dm0[data_index] <= data_wdata;
            if (data_we1) dm1[data_index] <= data_wdata;
        end
    end

    // Scoreboard
    int          tests;
    int          fails;
    logic [31:0] exp_resp  [$];
    logic [31:0] exp_raddr [$];
    logic [42:0] exp_dw    [$];   // {way, index[9:0], data}
    logic [28:0] exp_tw    [$];   // {way, set[7:0], tag[19:0]}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %h expected nothing at %0t", name, act, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    // Monitor: compares every DUT output event against the queues
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.cpu_resp_valid) begin
                if (exp_resp.size() == 0) unexpected("resp_unexpected", {32'h0, bus.cpu_resp_data});
                else chk("resp_data", {32'h0, bus.cpu_resp_data}, {32'h0, exp_resp.pop_front()});
            end
            if (bus.mem_rreq && bus.mem_rready) begin
                if (exp_raddr.size() == 0) unexpected("rreq_unexpected", {32'h0, bus.mem_raddr});
                else chk("mem_raddr", {32'h0, bus.mem_raddr}, {32'h0, exp_raddr.pop_front()});
            end
            if (data_we0 || data_we1) begin
                chk("data_we_onehot", {63'h0, data_we0 & data_we1}, 64'h0);
                if (exp_dw.size() == 0) unexpected("data_we_unexpected", {21'h0, data_we1, data_index, data_wdata});
                else chk("data_write", {21'h0, data_we1, data_index, data_wdata}, {21'h0, exp_dw.pop_front()});
            end
            if (tag_we0 || tag_we1) begin
                chk("tag_we_onehot", {63'h0, tag_we0 & tag_we1}, 64'h0);
                if (exp_tw.size() == 0) unexpected("tag_we_unexpected", {35'h0, tag_we1, tag_index, tag_wtag});
                else chk("tag_write", {35'h0, tag_we1, tag_index, tag_wtag}, {35'h0, exp_tw.pop_front()});
            end
        end
    end

    // One fetch: pushes expectations, drives the request and, on a miss,
    // plays the memory side. abort_beat >= 0 pulls rstn low on that beat.
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d, input bit miss,
                         input bit way, input int rdy_dly, input int gap, input int abort_beat);
        logic [1:0] bb;
        if (abort_beat < 0) exp_resp.push_back(exp_d);
        if (miss) begin
            exp_raddr.push_back({a[31:4], 4'b0000});
            if (abort_beat < 0) exp_tw.push_back({way, a[11:4], a[31:12]});
        end
        chk("req_ready_idle", {63'h0, bus.cpu_req_ready}, 64'h1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = a;
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        chk("req_ready_busy", {63'h0, bus.cpu_req_ready}, 64'h0);
        if (!miss) begin
            chk("hit_latency", {63'h0, bus.cpu_resp_valid}, 64'h1);
            chk("hit_no_rreq", {63'h0, bus.mem_rreq}, 64'h0);
            @(posedge clk); #1;
            return;
        end
        chk("miss_no_resp", {63'h0, bus.cpu_resp_valid}, 64'h0);
        @(posedge clk); #1;
        chk("miss_rreq", {63'h0, bus.mem_rreq}, 64'h1);
        for (int i = 0; i < rdy_dly; i++) begin
            chk("raddr_stable", {32'h0, bus.mem_raddr}, {32'h0, a[31:4], 4'b0000});
            @(posedge clk); #1;
        end
        bus.mem_rready = 1'b1;
        @(posedge clk); #1;
        bus.mem_rready = 1'b0;
        chk("rreq_dropped", {63'h0, bus.mem_rreq}, 64'h0);
        for (int b = 0; b < 4; b++) begin
            bb = b[1:0];
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_word({a[31:4], bb, 2'b00});
            if (b == abort_beat) begin
                rstn = 1'b0;
                @(posedge clk); #1;
                bus.mem_rvalid = 1'b0;
                chk("rst_req_ready", {63'h0, bus.cpu_req_ready}, 64'h1);
                chk("rst_rreq", {63'h0, bus.mem_rreq}, 64'h0);
                chk("rst_resp", {63'h0, bus.cpu_resp_valid}, 64'h0);
                chk("rst_we", {60'h0, tag_we0, tag_we1, data_we0, data_we1}, 64'h0);
                rstn = 1'b1;
                @(posedge clk); #1;
                chk("post_rst_ready", {63'h0, bus.cpu_req_ready}, 64'h1);
                return;
            end
            exp_dw.push_back({way, a[11:4], bb, mem_word({a[31:4], bb, 2'b00})});
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
            for (int g = 0; g < gap && b < 3; g++) begin
                @(posedge clk); #1;
            end
        end
        // RESP cycle
        chk("resp_pulse", {63'h0, bus.cpu_resp_valid}, 64'h1);
        @(posedge clk); #1;
        chk("resp_done", {63'h0, bus.cpu_resp_valid}, 64'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_addr  = 32'h0;
        bus.mem_rready    = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = 32'h0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("reset_ready", {63'h0, bus.cpu_req_ready}, 64'h1);
        chk("reset_rreq", {63'h0, bus.mem_rreq}, 64'h0);
        chk("reset_resp", {63'h0, bus.cpu_resp_valid}, 64'h0);

        // Cold miss, both ways invalid -> way 0, critical word A2
        fetch(32'h0000_1008, 32'hA000_1008, 1'b1, 1'b0, 0, 0, -1);
        // Hit in way 0
        fetch(32'h0000_100C, 32'hA000_100C, 1'b0, 1'b0, 0, 0, -1);
        // Same set: fills the invalid way 1
        fetch(32'h0000_2000, 32'hA000_2000, 1'b1, 1'b1, 0, 0, -1);
        // Both valid, LRU points at way 0 -> evicts tag 1
        fetch(32'h0000_3000, 32'hA000_3000, 1'b1, 1'b0, 1, 0, -1);
        // Evicted line misses again, LRU now way 1
        fetch(32'h0000_1000, 32'hA000_1000, 1'b1, 1'b1, 0, 1, -1);
        // Surviving line still hits in way 0
        fetch(32'h0000_3004, 32'hA000_3004, 1'b0, 1'b0, 0, 0, -1);
        // Slow memory: ready held off 5 cycles, 2-cycle gaps between beats
        fetch(32'h0000_4014, 32'hA000_4014, 1'b1, 1'b0, 5, 2, -1);
        fetch(32'h0000_401C, 32'hA000_401C, 1'b0, 1'b0, 0, 0, -1);
        // Reset lands on refill beat 2
        fetch(32'h0000_5020, 32'h0, 1'b1, 1'b0, 0, 0, 2);
        // Ways were cleared by reset: everything misses again
        fetch(32'h0000_5028, 32'hA000_5028, 1'b1, 1'b0, 0, 0, -1);
        fetch(32'h0000_100C, 32'hA000_100C, 1'b1, 1'b0, 0, 0, -1);
        fetch(32'h0000_1004, 32'hA000_1004, 1'b0, 1'b0, 0, 0, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("resp_queue_empty", {32'h0, 32'(exp_resp.size())}, 64'h0);
        chk("raddr_queue_empty", {32'h0, 32'(exp_raddr.size())}, 64'h0);
        chk("dw_queue_empty", {32'h0, 32'(exp_dw.size())}, 64'h0);
        chk("tw_queue_empty", {32'h0, 32'(exp_tw.size())}, 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
